sdr_ch3_arbiter: RTL and testbench
==================================

# sdr_ch3_arbiter

Sequences and shares SDRAM channel 3 between three requesters:
- the ROM loader write path, active during download;
- the BG2 tile fetcher (read);
- an auxiliary read/write port for NVRAM/hiscore/debug.

It sits between the core/rom loader and the `ch3_*` port of the `sdram` controller and replaces the ad-hoc download/BG2 mux. It enforces one outstanding SDRAM transaction, fixed priority with an anti-starvation rule, and a watchdog on missing `ready`.

## Interface
Parameters:
- `AW`, 24 — SDRAM word-address width.
- `STARVE_MAX`, 4 — consecutive BG2 grants after which a pending AUX request must win.
- `TIMEOUT`, 255 — cycles to wait for `mem_ready` before abandoning a transaction.

Ports:
- `clk` in 1 — SDRAM clock; the only clock.
- `reset` in 1 — synchronous, active-high.
- `rom_mode` in 1 — ROM download active; when high only the ROM requester is granted.
- `rom_req` in 1 — ROM write request, level, held until `rom_rdy`.
- `rom_addr` in AW — word address.
- `rom_din` in 16 — write data.
- `rom_be` in 2 — byte enables.
- `rom_rdy` out 1 — one-cycle completion pulse.
- `bg2_req` in 1 — read request, level, held until `bg2_rdy`.
- `bg2_addr` in AW — word address.
- `bg2_dout` out 16 — read data.
- `bg2_rdy` out 1 — one-cycle completion pulse.
- `aux_req` in 1 — request, level, held until `aux_rdy`.
- `aux_rnw` in 1 — 1 = read, 0 = write.
- `aux_addr` in AW — word address.
- `aux_din` in 16 — write data.
- `aux_be` in 2 — byte enables.
- `aux_dout` out 16 — read data.
- `aux_rdy` out 1 — one-cycle completion pulse.
- `mem_addr` out AW, `mem_din` out 16, `mem_be` out 2, `mem_rnw` out 1 — drive `ch3_*`.
- `mem_req` out 1 — one-cycle issue pulse.
- `mem_dout` in 16 — read data from the controller.
- `mem_ready` in 1 — one-cycle completion pulse from the controller.
- `busy` out 1 — a transaction is outstanding.
- `timeout_err` out 1 — sticky; cleared only by `reset`.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE: arbitration.** Priority order:
  - `rom_mode` high: only ROM is eligible; the BG2 and AUX requests are ignored and stay pending.
  - Otherwise: AUX wins if it is pending and `starve_cnt == STARVE_MAX`.
  - Otherwise: BG2 wins over AUX.
  - ROM requests while `rom_mode` is low are ignored.
- **Grant.** Register the grant and latch the winner's `addr`, `din`, `be` and `rnw` into the `mem_*` registers. ROM uses `rnw = 0`; BG2 uses `rnw = 1`. Then go to ISSUE.
- **ISSUE.** Assert `mem_req` for exactly one cycle. Go to WAIT and clear the watchdog counter.
- **WAIT.** Hold `mem_*` stable.
  - On `mem_ready`: capture `mem_dout` into the granted requester's `dout` register. Read grants only; writes leave `dout` unchanged. Pulse that requester's `rdy` on the next cycle and return to IDLE.
  - Watchdog: increment each cycle. When it reaches `TIMEOUT`, set `timeout_err`, pulse the requester's `rdy` (data = 16'hFFFF for reads) and return to IDLE.
  - A late `mem_ready` arriving in IDLE is ignored.
- **`starve_cnt`** (saturating, width clog2(STARVE_MAX+1)):
  - +1 on a BG2 grant while AUX is pending;
  - cleared on an AUX grant;
  - cleared when AUX is not pending.
- **`dout` registers** hold their value until the next completed read for that requester.
- **`busy`** is high in ISSUE and WAIT.
- **`rom_mode` changes** mid-transaction do not abort the in-flight transaction. They affect only the next arbitration.

## Timing
- **Reset values:** state IDLE; all `rdy`, `mem_req`, `busy`, `timeout_err` 0; `mem_*` 0; `dout` 0; `starve_cnt` 0.
- **Reset mid-transaction:** immediate return to IDLE. No `rdy` pulse is issued. The outstanding `mem_ready` is ignored.
- **Request path:** request seen in IDLE at cycle n → `mem_req` high at n+1 → `busy` high from n+1.
- **Completion path:** `mem_ready` at cycle m → `rdy` and `dout` valid at m+1 → IDLE at m+1 → the earliest next `mem_req` is at m+2.
- Minimum issue-to-issue spacing is 3 cycles plus the memory latency.
- A requester must deassert `req` in the cycle after its `rdy`. If `req` is still high in IDLE at that point, it is treated as a new request.
- **Simultaneous requests in the same cycle:** resolved purely by the priority rules.

## Test plan
- Reset, then `rom_mode=1` with `rom_req`, `rom_addr=24'h000010`, `rom_din=16'hA55A`, `rom_be=2'b11`. Required: `mem_req` one cycle later with `mem_rnw=0` and the same values. Model `mem_ready` after 5 cycles → `rom_rdy` pulse 1 cycle later.
- `rom_mode=1` with `bg2_req` and `aux_req` held. Required: no `mem_req` for 100 cycles. After `rom_mode` → 0: BG2 granted first.
- `bg2_req` and `aux_req` both continuously pending (BG2 re-requests immediately after each `bg2_rdy`). Required grant sequence: BG2 ×4, AUX, BG2 ×4, AUX.
- AUX read of `24'h123456` with the model returning `16'hBEEF`. Required: `aux_dout=16'hBEEF` at the `aux_rdy` cycle, held through a following BG2 read returning `16'h0001`.
- Model never asserts `mem_ready` for a BG2 read. Required: at issue+256 cycles `bg2_rdy` pulses with `bg2_dout=16'hFFFF` and `timeout_err=1`. A later `mem_ready` in IDLE causes no response.
- Assert `reset` during WAIT. Required: next cycle state IDLE and all outputs at reset values. A `mem_ready` 2 cycles later yields no `rdy` pulse.

Source files
------------

// File: rtl/sdr_ch3_arbiter.sv
// -----------------------------------------------------------------------------
// sdr_ch3_arbiter
//
// Shares SDRAM channel 3 between three requesters and keeps at most one
// transaction outstanding on the controller's ch3_* port:
//   - ROM loader write path (only requester served while rom_mode is high)
//   - BG2 tile fetcher (read only)
//   - auxiliary read/write port (NVRAM / hiscore / debug)
//
// Arbitration outside ROM download is BG2 over AUX. After STARVE_MAX
// consecutive BG2 grants made while AUX was waiting, AUX wins the next slot.
// A watchdog abandons a transaction if mem_ready has not arrived TIMEOUT
// cycles after the issue cycle. The requester still gets its rdy pulse (read
// data forced to 16'hFFFF), and timeout_err is latched until reset.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   rom_mode              : ROM download active
//   rom_req/addr/din/be   : ROM write request (level, held until rom_rdy)
//   rom_rdy               : ROM completion pulse
//   bg2_req/addr          : BG2 read request (level, held until bg2_rdy)
//   bg2_dout, bg2_rdy     : BG2 read data, completion pulse
//   aux_req/rnw/addr/din/be : AUX request (level, held until aux_rdy)
//   aux_dout, aux_rdy     : AUX read data, completion pulse
//   mem_addr/din/be/rnw   : latched command towards ch3_*
//   mem_req               : one-cycle issue pulse
//   mem_dout, mem_ready   : controller read data and completion pulse
//   busy                  : transaction outstanding (ISSUE or WAIT)
//   timeout_err           : sticky watchdog flag
// -----------------------------------------------------------------------------
module sdr_ch3_arbiter #(
    parameter int AW         = 24,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          rom_mode,
    input  logic          rom_req,
    input  logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_din,
    input  logic [1:0]    rom_be,
    output logic          rom_rdy,

    input  logic          bg2_req,
    input  logic [AW-1:0] bg2_addr,
    output logic [15:0]   bg2_dout,
    output logic          bg2_rdy,

    input  logic          aux_req,
    input  logic          aux_rnw,
    input  logic [AW-1:0] aux_addr,
    input  logic [15:0]   aux_din,
    input  logic [1:0]    aux_be,
    output logic [15:0]   aux_dout,
    output logic          aux_rdy,

    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_be,
    output logic          mem_rnw,
    output logic          mem_req,
    input  logic [15:0]   mem_dout,
    input  logic          mem_ready,

    output logic          busy,
    output logic          timeout_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    // The watchdog is cleared in ISSUE and counts from the first WAIT cycle,
    // so the value TIMEOUT-1 marks the last WAIT cycle; the abandon
    // response then lands TIMEOUT+1 cycles after the issue pulse.
    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ROM  = 2'd1,
        SRC_BG2  = 2'd2,
        SRC_AUX  = 2'd3
    } src_t;

    // One-hot completion pulses {aux, bg2, rom} for a granted source.
    function automatic logic [2:0] rdy_vec(input src_t src);
        logic [2:0] v;
        case (src)
            SRC_ROM: v = 3'b001;
            SRC_BG2: v = 3'b010;
            SRC_AUX: v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    state_t          state_r;
    src_t            gnt_r;
    src_t            win_s;
    logic [SW-1:0]   starve_cnt_r;
    logic [WW-1:0]   wdog_r;

    logic [AW-1:0]   mem_addr_r;
    logic [15:0]     mem_din_r;
    logic [1:0]      mem_be_r;
    logic            mem_rnw_r;
    logic            mem_req_r;
    logic            busy_r;
    logic            timeout_err_r;
    logic            rom_rdy_r;
    logic            bg2_rdy_r;
    logic            aux_rdy_r;
    logic [15:0]     bg2_dout_r;
    logic [15:0]     aux_dout_r;

    logic            finish_s;
    logic [15:0]     ret_data_s;

    // Select the winner among current requests (only meaningful in IDLE).
    always_comb begin
        win_s = SRC_NONE;
        if (rom_mode) begin
            if (rom_req) begin
                win_s = SRC_ROM;
            end else begin
                win_s = SRC_NONE;
            end
        end else if (aux_req && (starve_cnt_r == STARVE_LIM)) begin
            win_s = SRC_AUX;
        end else if (bg2_req) begin
            win_s = SRC_BG2;
        end else if (aux_req) begin
            win_s = SRC_AUX;
        end else begin
            win_s = SRC_NONE;
        end
    end

    // Transaction end (data or watchdog) and the data returned to a reader.
    always_comb begin
        finish_s   = 1'b0;
        ret_data_s = 16'hFFFF;
        if (state_r == ST_WAIT) begin
            finish_s = mem_ready || (wdog_r == WDOG_LAST);
        end else begin
            finish_s = 1'b0;
        end
        if (mem_ready) begin
            ret_data_s = mem_dout;
        end else begin
            ret_data_s = 16'hFFFF;
        end
    end

    // Main sequencer: grant/latch, issue pulse, wait with watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            gnt_r         <= SRC_NONE;
            wdog_r        <= {WW{1'b0}};
            mem_addr_r    <= {AW{1'b0}};
            mem_din_r     <= 16'h0000;
            mem_be_r      <= 2'b00;
            mem_rnw_r     <= 1'b0;
            mem_req_r     <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            rom_rdy_r     <= 1'b0;
            bg2_rdy_r     <= 1'b0;
            aux_rdy_r     <= 1'b0;
        end else begin
            mem_req_r <= 1'b0;
            rom_rdy_r <= 1'b0;
            bg2_rdy_r <= 1'b0;
            aux_rdy_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A late mem_ready seen here is deliberately ignored.
                    if (win_s != SRC_NONE) begin
                        gnt_r     <= win_s;
                        mem_req_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= ST_ISSUE;
                        case (win_s)
                            SRC_ROM: begin
                                mem_addr_r <= rom_addr;
                                mem_din_r  <= rom_din;
                                mem_be_r   <= rom_be;
                                mem_rnw_r  <= 1'b0;
                            end
                            SRC_BG2: begin
                                mem_addr_r <= bg2_addr;
                                mem_din_r  <= 16'h0000;
                                mem_be_r   <= 2'b11;
                                mem_rnw_r  <= 1'b1;
                            end
                            SRC_AUX: begin
                                mem_addr_r <= aux_addr;
                                mem_din_r  <= aux_din;
                                mem_be_r   <= aux_be;
                                mem_rnw_r  <= aux_rnw;
                            end
                            default: begin
                                mem_addr_r <= mem_addr_r;
                                mem_din_r  <= mem_din_r;
                                mem_be_r   <= mem_be_r;
                                mem_rnw_r  <= mem_rnw_r;
                            end
                        endcase
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    wdog_r  <= {WW{1'b0}};
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        {aux_rdy_r, bg2_rdy_r, rom_rdy_r} <= rdy_vec(gnt_r);
                        gnt_r   <= SRC_NONE;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (wdog_r == WDOG_LAST) begin
                        {aux_rdy_r, bg2_rdy_r, rom_rdy_r} <= rdy_vec(gnt_r);
                        timeout_err_r <= 1'b1;
                        gnt_r         <= SRC_NONE;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        wdog_r <= wdog_r + WW'(1);
                    end
                end
                default: begin
                    gnt_r   <= SRC_NONE;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Anti-starvation count of BG2 grants taken while AUX was waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if ((state_r == ST_IDLE) && (win_s == SRC_BG2) && aux_req) begin
            if (starve_cnt_r != STARVE_LIM) begin
                starve_cnt_r <= starve_cnt_r + SW'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else if ((state_r == ST_IDLE) && (win_s == SRC_AUX)) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (!aux_req) begin
            starve_cnt_r <= {SW{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // BG2 read data; holds until the next completed BG2 read.
    always_ff @(posedge clk) begin
        if (reset) begin
            bg2_dout_r <= 16'h0000;
        end else if (finish_s && mem_rnw_r && (gnt_r == SRC_BG2)) begin
            bg2_dout_r <= ret_data_s;
        end else begin
            bg2_dout_r <= bg2_dout_r;
        end
    end

    // AUX read data; AUX writes leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            aux_dout_r <= 16'h0000;
        end else if (finish_s && mem_rnw_r && (gnt_r == SRC_AUX)) begin
            aux_dout_r <= ret_data_s;
        end else begin
            aux_dout_r <= aux_dout_r;
        end
    end

    assign mem_addr    = mem_addr_r;
    assign mem_din     = mem_din_r;
    assign mem_be      = mem_be_r;
    assign mem_rnw     = mem_rnw_r;
    assign mem_req     = mem_req_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;
    assign rom_rdy     = rom_rdy_r;
    assign bg2_rdy     = bg2_rdy_r;
    assign aux_rdy     = aux_rdy_r;
    assign bg2_dout    = bg2_dout_r;
    assign aux_dout    = aux_dout_r;

endmodule

// File: tb/tb_sdr_ch3_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sdr_ch3_arbiter. A transaction-level model keeps the
// pending requests, the starvation count and the expected read data, and
// predicts each grant from the arbitration rules. Directed scenarios are
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_sdr_ch3_arbiter;

    localparam int AW   = 24;
    localparam int SMAX = 4;
    localparam int TMO  = 255;

    logic          clk;
    logic          reset;
    logic          rom_mode;
    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_din;
    logic [1:0]    rom_be;
    logic          rom_rdy;
    logic          bg2_req;
    logic [AW-1:0] bg2_addr;
    logic [15:0]   bg2_dout;
    logic          bg2_rdy;
    logic          aux_req;
    logic          aux_rnw;
    logic [AW-1:0] aux_addr;
    logic [15:0]   aux_din;
    logic [1:0]    aux_be;
    logic [15:0]   aux_dout;
    logic          aux_rdy;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_be;
    logic          mem_rnw;
    logic          mem_req;
    logic [15:0]   mem_dout;
    logic          mem_ready;
    logic          busy;
    logic          timeout_err;

    sdr_ch3_arbiter #(.AW(AW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .rom_mode(rom_mode), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_din(rom_din), .rom_be(rom_be), .rom_rdy(rom_rdy),
        .bg2_req(bg2_req), .bg2_addr(bg2_addr), .bg2_dout(bg2_dout), .bg2_rdy(bg2_rdy),
        .aux_req(aux_req), .aux_rnw(aux_rnw), .aux_addr(aux_addr), .aux_din(aux_din),
        .aux_be(aux_be), .aux_dout(aux_dout), .aux_rdy(aux_rdy),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be), .mem_rnw(mem_rnw),
        .mem_req(mem_req), .mem_dout(mem_dout), .mem_ready(mem_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (index 0 = ROM, 1 = BG2, 2 = AUX).
    int            starve_m;
    logic [15:0]   bg2_dout_m;
    logic [15:0]   aux_dout_m;
    logic          err_m;
    bit            pend [3];
    logic [AW-1:0] q_addr [3];
    logic [15:0]   q_din [3];
    logic [1:0]    q_be [3];
    bit            aux_rd;

    int exp_seq [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        rom_req  = pend[0];
        rom_addr = q_addr[0];
        rom_din  = q_din[0];
        rom_be   = q_be[0];
        bg2_req  = pend[1];
        bg2_addr = q_addr[1];
        aux_req  = pend[2];
        aux_addr = q_addr[2];
        aux_din  = q_din[2];
        aux_be   = q_be[2];
        aux_rnw  = aux_rd;
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [15:0] d,
                           input logic [1:0] b);
        pend[idx]   = 1'b1;
        q_addr[idx] = a;
        q_din[idx]  = d;
        q_be[idx]   = b;
    endtask

    task automatic model_reset();
        starve_m   = 0;
        bg2_dout_m = 16'h0000;
        aux_dout_m = 16'h0000;
        err_m      = 1'b0;
    endtask

    // Winner by the priority rules: ROM only in download mode, starved AUX,
    // then BG2, then AUX.
    function automatic int model_winner();
        if (rom_mode) return pend[0] ? 0 : -1;
        if (pend[2] && starve_m == SMAX) return 2;
        if (pend[1]) return 1;
        if (pend[2]) return 2;
        return -1;
    endfunction

    // Starvation count bookkeeping for one arbitration edge.
    task automatic model_edge(input int win);
        if (win == 1 && pend[2]) starve_m = (starve_m < SMAX) ? starve_m + 1 : SMAX;
        else if (win == 2) starve_m = 0;
        else if (!pend[2]) starve_m = 0;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_rom_rdy"}, rom_rdy, 0);
        check_eq({tag, "_bg2_rdy"}, bg2_rdy, 0);
        check_eq({tag, "_aux_rdy"}, aux_rdy, 0);
        check_eq({tag, "_mem_req"}, mem_req, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_err"}, timeout_err, 0);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_eq({tag, "_mem_din"}, mem_din, 0);
        check_eq({tag, "_mem_be"}, mem_be, 0);
        check_eq({tag, "_mem_rnw"}, mem_rnw, 0);
        check_eq({tag, "_bg2_dout"}, bg2_dout, 0);
        check_eq({tag, "_aux_dout"}, aux_dout, 0);
    endtask

    // One full transaction from the current (IDLE) cycle to the rdy cycle.
    // lat = WAIT cycles before mem_ready; the winner drops req in the rdy cycle.
    task automatic run_txn(input int lat, input logic [15:0] rdata, output int got);
        int         win;
        bit         rd;
        int         stray;
        logic [2:0] rv;
        logic [2:0] ev;
        win = model_winner();
        got = -1;
        if (win < 0) begin
            check_eq("txn_has_winner", 0, 1);
            return;
        end
        rd = (win == 1) || (win == 2 && aux_rd);
        model_edge(win);
        tick();
        check_eq("issue_req", mem_req, 1);
        check_eq("issue_busy", busy, 1);
        check_eq("issue_addr", mem_addr, q_addr[win]);
        check_eq("issue_rnw", mem_rnw, rd);
        if (win != 1) begin
            check_eq("issue_din", mem_din, q_din[win]);
            check_eq("issue_be", mem_be, q_be[win]);
        end
        tick();
        check_eq("req_one_cycle", mem_req, 0);
        stray = 0;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) tick();
            if (rom_rdy || bg2_rdy || aux_rdy || mem_req || !busy || mem_addr !== q_addr[win])
                stray++;
        end
        check_eq("wait_quiet", stray, 0);
        mem_dout  = rdata;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_dout  = 16'($urandom);
        rv = {aux_rdy, bg2_rdy, rom_rdy};
        ev = 3'b000;
        ev[win] = 1'b1;
        check_eq("rdy_pulse", rv, ev);
        check_eq("done_busy", busy, 0);
        if (rd && win == 1) bg2_dout_m = rdata;
        if (rd && win == 2) aux_dout_m = rdata;
        check_eq("bg2_dout", bg2_dout, bg2_dout_m);
        check_eq("aux_dout", aux_dout, aux_dout_m);
        check_eq("timeout_err", timeout_err, err_m);
        got = rv[0] ? 0 : (rv[1] ? 1 : (rv[2] ? 2 : -1));
        pend[win] = 1'b0;
        drive_reqs();
    endtask

    initial begin
        int g;
        int cnt;
        int w;
        reset     = 1'b1;
        rom_mode  = 1'b0;
        mem_ready = 1'b0;
        mem_dout  = 16'h0000;
        aux_rd    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; q_addr[i] = '0; q_din[i] = '0; q_be[i] = '0;
        end
        drive_reqs();
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        check_reset_outs("rst");

        // ROM download write.
        rom_mode = 1'b1;
        set_req(0, 24'h000010, 16'hA55A, 2'b11);
        drive_reqs();
        run_txn(4, 16'h5555, g);
        check_eq("rom_gnt", g, 0);

        // Download mode blocks BG2 and AUX.
        set_req(1, 24'h000200, 16'h0000, 2'b11);
        set_req(2, 24'h000300, 16'h0000, 2'b11);
        aux_rd = 1'b1;
        drive_reqs();
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            model_edge(-1);
            tick();
            if (mem_req || busy) cnt++;
        end
        check_eq("romode_quiet", cnt, 0);
        rom_mode = 1'b0;
        run_txn(2, 16'h1111, g);
        check_eq("after_romode_gnt", g, 1);

        // Anti-starvation grant sequence with both continuously pending.
        pend[2] = 1'b0;
        drive_reqs();
        model_edge(-1);
        tick();
        set_req(1, 24'($urandom), 16'h0000, 2'b11);
        set_req(2, 24'($urandom), 16'($urandom), 2'b11);
        aux_rd = 1'b1;
        drive_reqs();
        for (int k = 0; k < 10; k++) begin
            run_txn($urandom_range(0, 3), 16'($urandom), g);
            check_eq($sformatf("seq_%0d", k), g, exp_seq[k]);
            if (!pend[1]) set_req(1, 24'($urandom), 16'h0000, 2'b11);
            if (!pend[2]) set_req(2, 24'($urandom), 16'($urandom), 2'b11);
            drive_reqs();
        end

        // AUX read data held across a later BG2 read.
        pend[1] = 1'b0;
        pend[2] = 1'b0;
        drive_reqs();
        model_edge(-1);
        tick();
        set_req(2, 24'h123456, 16'h0000, 2'b11);
        aux_rd = 1'b1;
        drive_reqs();
        run_txn(3, 16'hBEEF, g);
        check_eq("aux_beef", aux_dout, 16'hBEEF);
        set_req(1, 24'h000777, 16'h0000, 2'b11);
        drive_reqs();
        run_txn(2, 16'h0001, g);
        check_eq("aux_hold", aux_dout, 16'hBEEF);
        check_eq("bg2_0001", bg2_dout, 16'h0001);

        // Watchdog on a BG2 read that never completes.
        set_req(1, 24'h0ABCDE, 16'h0000, 2'b11);
        drive_reqs();
        model_edge(model_winner());
        tick();
        check_eq("tmo_issue", mem_req, 1);
        cnt = 0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (bg2_rdy || timeout_err) cnt++;
        end
        check_eq("tmo_early", cnt, 0);
        tick();
        pend[1] = 1'b0;
        drive_reqs();
        err_m      = 1'b1;
        bg2_dout_m = 16'hFFFF;
        check_eq("tmo_rdy", bg2_rdy, 1);
        check_eq("tmo_dout", bg2_dout, 16'hFFFF);
        check_eq("tmo_err", timeout_err, 1);
        check_eq("tmo_busy", busy, 0);
        model_edge(-1);
        tick();
        mem_dout  = 16'h4321;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check_eq("late_rdy", {aux_rdy, bg2_rdy, rom_rdy}, 3'b000);
        check_eq("late_req", mem_req, 0);
        tick();
        check_eq("late_rdy2", {aux_rdy, bg2_rdy, rom_rdy}, 3'b000);
        check_eq("late_dout", bg2_dout, 16'hFFFF);
        check_eq("late_err", timeout_err, 1);

        // Reset while an AUX write is waiting for the controller.
        set_req(2, 24'h00F00D, 16'h3C3C, 2'b01);
        aux_rd = 1'b0;
        drive_reqs();
        model_edge(model_winner());
        tick();
        tick();
        tick();
        check_eq("pre_rst_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pend[2] = 1'b0;
        drive_reqs();
        model_reset();
        check_reset_outs("wrst");
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check_eq("wrst_rdy", {aux_rdy, bg2_rdy, rom_rdy}, 3'b000);
        tick();
        check_eq("wrst_rdy2", {aux_rdy, bg2_rdy, rom_rdy}, 3'b000);
        check_eq("wrst_busy", busy, 0);

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            rom_mode = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 24'($urandom), 16'($urandom), 2'($urandom));
                    if (i == 2) aux_rd = 1'($urandom);
                end
            end
            drive_reqs();
            w = model_winner();
            if (w < 0) begin
                for (int k = 0; k < 2; k++) begin
                    model_edge(-1);
                    tick();
                    check_eq("rnd_idle", {mem_req, busy}, 2'b00);
                end
            end else begin
                run_txn($urandom_range(0, 6), 16'($urandom), g);
                check_eq("rnd_gnt", g, w);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
